// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - key indices, scan classes and command states for the keypad controller
package teclado_pkg;

  // 4x4 layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, index = r*4+c
  localparam logic [3:0] K_1    = 4'd0;
  localparam logic [3:0] K_2    = 4'd1;
  localparam logic [3:0] K_3    = 4'd2;
  localparam logic [3:0] K_A    = 4'd3;
  localparam logic [3:0] K_4    = 4'd4;
  localparam logic [3:0] K_5    = 4'd5;
  localparam logic [3:0] K_6    = 4'd6;
  localparam logic [3:0] K_B    = 4'd7;
  localparam logic [3:0] K_7    = 4'd8;
  localparam logic [3:0] K_8    = 4'd9;
  localparam logic [3:0] K_9    = 4'd10;
  localparam logic [3:0] K_C    = 4'd11;
  localparam logic [3:0] K_STAR = 4'd12;
  localparam logic [3:0] K_0    = 4'd13;
  localparam logic [3:0] K_HASH = 4'd14;
  localparam logic [3:0] K_D    = 4'd15;

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} scan_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DIG1, ST_DIG2} cmd_state_e;

  function automatic logic key_is_digit(input logic [3:0] k);
    return (k != K_A) && (k != K_B) && (k != K_C) && (k != K_D) &&
           (k != K_STAR) && (k != K_HASH);
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] k);
    case (k)
      K_1:     return 4'd1;
      K_2:     return 4'd2;
      K_3:     return 4'd3;
      K_4:     return 4'd4;
      K_5:     return 4'd5;
      K_6:     return 4'd6;
      K_7:     return 4'd7;
      K_8:     return 4'd8;
      K_9:     return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/teclado_scan.sv
// rtl/teclado_scan.sv - row scanner, column synchronizer, scan classifier and debounce
module teclado_scan
  import teclado_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ROW_HZ    = 1000,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DEB_SCANS = 4,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] columna,
  output logic [ROWS-1:0] fila,
  output logic [KW-1:0]   key_code,
  output logic            key_valid
);

  localparam int SCAN_DIV = (CLK_HZ / ROW_HZ < 4) ? 4 : CLK_HZ / ROW_HZ;
  localparam int NK  = ROWS * COLS;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DEB = (DEB_SCANS < 1) ? 1 : DEB_SCANS;
  localparam int CW  = $clog2(DEB + 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N      = CW'(DEB);

  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [COLS-1:0] sync1_q, sync2_q;
  logic [NK-1:0]   snap_q, snap_d, snap_full;
  scan_class_e     cand_cls_q, cand_cls_d, stab_cls_q, stab_cls_d, scan_cls;
  logic [KW-1:0]   cand_key_q, cand_key_d, hit_key;
  logic [CW-1:0]   rep_q, rep_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic [1:0]      n_set;
  logic            same;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      dwell_q     <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      snap_q      <= '0;
      cand_cls_q  <= CLS_NONE;
      cand_key_q  <= '0;
      stab_cls_q  <= CLS_NONE;
      rep_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      sync1_q     <= columna;
      sync2_q     <= sync1_q;
      snap_q      <= snap_d;
      cand_cls_q  <= cand_cls_d;
      cand_key_q  <= cand_key_d;
      stab_cls_q  <= stab_cls_d;
      rep_q       <= rep_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Classify the snapshot as it will look once the current row is merged in.
  always_comb begin
    snap_full = snap_q;
    snap_full[row_q*COLS +: COLS] = ~sync2_q;
    n_set   = 2'd0;
    hit_key = '0;
    for (int i = 0; i < NK; i++) begin
      if (snap_full[i]) begin
        if (n_set != 2'd2) n_set = n_set + 2'd1;
        hit_key = KW'(i);
      end
    end
    case (n_set)
      2'd0:    scan_cls = CLS_NONE;
      2'd1:    scan_cls = CLS_SINGLE;
      default: scan_cls = CLS_MULTI;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    dwell_d     = dwell_q + DW'(1);
    snap_d      = snap_q;
    cand_cls_d  = cand_cls_q;
    cand_key_d  = cand_key_q;
    stab_cls_d  = stab_cls_q;
    rep_d       = rep_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    same        = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      snap_d  = snap_full;
      row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      if (row_q == ROW_LAST) begin
        same = (scan_cls == cand_cls_q) &&
               ((scan_cls != CLS_SINGLE) || (hit_key == cand_key_q));
        rep_d      = !same ? CW'(1) : ((rep_q == DEB_N) ? rep_q : rep_q + CW'(1));
        cand_cls_d = scan_cls;
        cand_key_d = hit_key;
        // Only a debounced NONE->SINGLE edge is an event; a release must come first.
        if ((rep_d == DEB_N) && (scan_cls != stab_cls_q)) begin
          stab_cls_d = scan_cls;
          if ((stab_cls_q == CLS_NONE) && (scan_cls == CLS_SINGLE)) begin
            key_valid_d = 1'b1;
            key_code_d  = hit_key;
          end
        end
      end
    end
  end

  assign fila      = ~(ROWS'(1) << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: rtl/teclado_ctrl.sv
// rtl/teclado_ctrl.sv - keypad controller top: scanner plus speed/turn command FSM
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ROW_HZ    = 1000,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DEB_SCANS = 4,
  parameter int SPEED_W   = 4,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic [COLS-1:0]    columna,
  output logic [ROWS-1:0]    fila,
  output logic [KW-1:0]      key_code,
  output logic               key_valid,
  output logic [SPEED_W-1:0] speed,
  output logic               turn,
  output logic               is_done,
  output logic               err
);

  localparam int SPEED_MAX = (1 << SPEED_W) - 1;

  cmd_state_e         state_q, state_d;
  logic [6:0]         acc_q, acc_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               turn_q, turn_d, done_q, done_d, err_q, err_d;
  logic [31:0]        key_ext;
  logic [3:0]         key4;
  logic               key_ev;

  teclado_scan #(
    .CLK_HZ(CLK_HZ), .ROW_HZ(ROW_HZ), .ROWS(ROWS), .COLS(COLS), .DEB_SCANS(DEB_SCANS)
  ) u_scan (
    .clk(clk100), .rst_n(rst_n), .columna(columna), .fila(fila),
    .key_code(key_code), .key_valid(key_valid)
  );

  // Codes beyond the 4x4 layout are reported but carry no command.
  assign key_ext = 32'(key_code);
  assign key4    = key_ext[3:0];
  assign key_ev  = key_valid && (key_ext < 32'd16);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      speed_q <= '0;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      speed_q <= speed_d;
      turn_q  <= turn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_ev) begin
      if (key_is_digit(key4))
        state_d = (state_q == ST_IDLE) ? ST_DIG1 : ST_DIG2;
      else if ((key4 == K_HASH) || (key4 == K_STAR) || (key4 == K_C))
        state_d = ST_IDLE;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    speed_d = speed_q;
    turn_d  = turn_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (key_ev) begin
      if (key_is_digit(key4)) begin
        case (state_q)
          ST_IDLE: acc_d = 7'(key_digit(key4));
          ST_DIG1: acc_d = acc_q * 7'd10 + 7'(key_digit(key4));
          default: err_d = 1'b1;
        endcase
      end else begin
        case (key4)
          K_HASH: begin
            if (state_q == ST_IDLE) begin
              err_d = 1'b1;
            end else begin
              speed_d = (32'(acc_q) > SPEED_MAX) ? SPEED_W'(SPEED_MAX) : SPEED_W'(acc_q);
              done_d  = 1'b1;
              acc_d   = '0;
            end
          end
          K_STAR: acc_d = '0;
          K_A:    turn_d = 1'b0;
          K_B:    turn_d = 1'b1;
          K_C: begin
            speed_d = '0;
            done_d  = 1'b1;
            acc_d   = '0;
          end
          K_D:     err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign speed   = speed_q;
  assign turn    = turn_q;
  assign is_done = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_teclado_ctrl.sv
// tb/tb_teclado_ctrl.sv - randomized scoreboard bench for teclado_ctrl with a keypad model
module tb_teclado_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN = 32;

  typedef struct {
    int speed;
    int turn;
    int done;
    int err;
  } post_t;

  logic       clk100 = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] columna, fila, key_code, speed;
  logic       key_valid, turn, is_done, err;
  logic [15:0] pressed = '0;

  int    n_cmp  = 0;
  int    n_fail = 0;
  string layout = "123A456B789C*0#D";

  int    exp_key_q[$];
  post_t exp_post_q[$];
  int    m_entry[$];
  int    m_speed = 0;
  int    m_turn  = 0;

  post_t mon_p;
  int    mon_k;
  bit    kv_prev = 1'b0;

  teclado_ctrl #(
    .CLK_HZ(32), .ROW_HZ(4), .ROWS(ROWS), .COLS(COLS), .DEB_SCANS(2), .SPEED_W(4)
  ) dut (
    .clk100(clk100), .rst_n(rst_n), .columna(columna), .fila(fila),
    .key_code(key_code), .key_valid(key_valid), .speed(speed), .turn(turn),
    .is_done(is_done), .err(err)
  );

  always #5 clk100 = ~clk100;

  always_comb begin
    columna = '1;
    for (int r = 0; r < ROWS; r++)
      if (!fila[r])
        for (int c = 0; c < COLS; c++)
          if (pressed[r*COLS+c]) columna[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
  endtask

  // Reference model: entry buffer of digits, evaluated arithmetically on '#'.
  task automatic model_key(input int code);
    post_t p;
    byte   ch;
    int    val;
    ch = layout[code];
    p.done = 0;
    p.err  = 0;
    if (ch >= "0" && ch <= "9") begin
      if (m_entry.size() < 2) m_entry.push_back(int'(ch) - 48);
      else p.err = 1;
    end else begin
      case (ch)
        "#": begin
          if (m_entry.size() == 0) begin
            p.err = 1;
          end else begin
            val = 0;
            foreach (m_entry[i]) val = val * 10 + m_entry[i];
            m_speed = (val > 15) ? 15 : val;
            p.done  = 1;
            m_entry.delete();
          end
        end
        "*": m_entry.delete();
        "A": m_turn = 0;
        "B": m_turn = 1;
        "C": begin
          m_speed = 0;
          p.done  = 1;
          m_entry.delete();
        end
        default: p.err = 1;
      endcase
    end
    p.speed = m_speed;
    p.turn  = m_turn;
    exp_key_q.push_back(code);
    exp_post_q.push_back(p);
  endtask

  always @(negedge clk100) begin
    if (kv_prev) begin
      if (exp_post_q.size() == 0) begin
        unexpected("post_state", int'(speed));
      end else begin
        mon_p = exp_post_q.pop_front();
        check("speed", int'(speed), mon_p.speed);
        check("turn", int'(turn), mon_p.turn);
        check("is_done", int'(is_done), mon_p.done);
        check("err", int'(err), mon_p.err);
      end
    end else if (is_done || err) begin
      unexpected("stray_pulse", int'({is_done, err}));
    end
    if (key_valid) begin
      if (exp_key_q.size() == 0) begin
        unexpected("key_valid", int'(key_code));
      end else begin
        mon_k = exp_key_q.pop_front();
        check("key_code", int'(key_code), mon_k);
      end
    end
    kv_prev = key_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk100);
  endtask

  function automatic int code_of(input byte ch);
    for (int i = 0; i < 16; i++)
      if (layout[i] == ch) return i;
    return 0;
  endfunction

  task automatic press(input int code, input int bounces);
    model_key(code);
    for (int b = 0; b < bounces; b++) begin
      pressed[code] = ~pressed[code];
      wait_cycles($urandom_range(2, 7));
    end
    pressed       = '0;
    pressed[code] = 1'b1;
    wait_cycles(4 * SCAN + $urandom_range(0, 16));
    pressed = '0;
    wait_cycles(4 * SCAN + $urandom_range(0, 16));
  endtask

  task automatic press_str(input string s);
    for (int i = 0; i < s.len(); i++) press(code_of(s[i]), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fila"}, int'(fila), 14);
    check({tag, "_key_code"}, int'(key_code), 0);
    check({tag, "_key_valid"}, int'(key_valid), 0);
    check({tag, "_speed"}, int'(speed), 0);
    check({tag, "_turn"}, int'(turn), 0);
    check({tag, "_is_done"}, int'(is_done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk100);
    rst_n = 1'b1;
    wait_cycles(2 * SCAN);

    press(code_of("5"), 3);
    press_str("12#");
    press_str("99#");
    press_str("7#");
    press_str("#");

    pressed = 16'h0003;
    wait_cycles(5 * SCAN);
    pressed = 16'h0002;
    wait_cycles(5 * SCAN);
    pressed = '0;
    wait_cycles(5 * SCAN);

    press_str("456");
    press_str("B#");
    press_str("1C");

    for (int i = 0; i < 24; i++) press($urandom_range(0, 15), $urandom_range(0, 3));

    press_str("B9#3");
    wait_cycles(13);
    rst_n = 1'b0;
    m_entry.delete();
    m_speed = 0;
    m_turn  = 0;
    #2;
    check_reset_outputs("midreset");
    wait_cycles(3);
    rst_n = 1'b1;
    @(negedge clk100);
    check("fila_after_release", int'(fila), 14);
    press_str("#");

    wait_cycles(4 * SCAN);
    check("exp_key_left", exp_key_q.size(), 0);
    check("exp_post_left", exp_post_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/teclado_ctrl.md
# teclado_ctrl

Parametrised matrix-keypad controller for the DC-motor education module. It scans a ROWS×COLS keypad, debounces it, and emits clean single-press key events. A command FSM turns those events into motor set-points: speed, turn and a done strobe. It replaces the fixed 4×4 scanner/decoder pair with derived scan timing, multi-key rejection, two-digit speed entry with clamping, and an error strobe.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- ROW_HZ, 1000, row-dwell rate; SCAN_DIV = CLK_HZ/ROW_HZ cycles per row, minimum 4
- ROWS, 4, keypad rows
- COLS, 4, keypad columns
- DEB_SCANS, 4, consecutive identical full scans needed to accept a new keypad state, minimum 1
- SPEED_W, 4, speed width; SPEED_MAX = 2^SPEED_W−1
- clk100  in  1  system clock; the single clock of the block
- rst_n  in  1  asynchronous, active-low reset
- columna  in  COLS  column sense; active-low (pulled up, 0 = key closed in the driven row)
- fila  out  ROWS  row drive; exactly one bit low, the rest high
- key_code  out  KW=$clog2(ROWS*COLS)  index of the last accepted key, r*COLS+c
- key_valid  out  1  one-cycle pulse when a new key is accepted
- speed  out  SPEED_W  committed speed set-point
- turn  out  1  direction: 0 forward, 1 reverse
- is_done  out  1  one-cycle pulse when speed is committed or stopped
- err  out  1  one-cycle pulse on a rejected command

## Operation
- Scan:
  - Row counter r cycles 0..ROWS−1; fila = ~(1<<r).
  - Dwell counter counts 0..SCAN_DIV−1.
  - columna is double-flopped. The synchronized value is sampled on dwell count SCAN_DIV−1 into snapshot bits [r*COLS +: COLS], after inversion.
  - After row ROWS−1 is sampled, the snapshot is complete: one full scan.
- Classify each full scan as NONE (0 keys), SINGLE(k) (exactly one key k), or MULTI (≥2 keys).
- Debounce:
  - A candidate class that repeats for DEB_SCANS consecutive scans becomes the stable class.
  - Any differing scan restarts the repeat count at 1.
- Event: key_valid pulses and key_code latches k only on a stable transition NONE→SINGLE(k).
  - SINGLE→SINGLE(other), SINGLE→MULTI and MULTI→SINGLE produce no event.
  - A release to NONE is required before the next event.
- Command FSM states are IDLE, DIG1 and DIG2. The accumulator acc is 7-bit decimal. Key map (4×4 layout) is: row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 * 0 # D.
- Digit key:
  - IDLE→DIG1, acc=d.
  - DIG1→DIG2, acc=acc*10+d.
  - In DIG2, the digit is ignored, err pulses, and the state is held.
- '#':
  - From DIG1 or DIG2: speed = min(acc, SPEED_MAX), is_done pulses, state→IDLE.
  - From IDLE: err pulses and speed is unchanged.
- '*': acc=0, state→IDLE, no pulse.
- 'A' sets turn=0; 'B' sets turn=1. Both apply immediately in any state and leave entry state unchanged.
- 'C' (stop): speed=0, is_done pulses, acc=0, state→IDLE.
- 'D': err pulses, otherwise no effect.
- For key codes ≥16 (ROWS*COLS>16): key_valid/key_code still report them; the FSM ignores them.

## Timing
- Reset values: fila=~1 (row 0 driven), both counters 0, snapshot 0, stable class NONE, repeat count 0, key_code 0, key_valid 0, speed 0, turn 0, is_done 0, err 0, FSM IDLE, acc 0.
- key_valid is registered and asserts the cycle after the final sample of the qualifying scan.
- speed, turn, is_done and err update the cycle after key_valid, giving 1-cycle FSM latency.
- Worst-case press-to-key_valid latency is (DEB_SCANS+1)·ROWS·SCAN_DIV+3 cycles.
- Pulses are exactly one cycle wide. At most one key event occurs per full scan, so events cannot collide.
- Reset asserted mid-scan or mid-entry clears everything asynchronously; partial entry is lost. Scanning restarts at row 0 on the first clock after release.

## Structure
- Package teclado_pkg contains:
  - key-index constants (K_0..K_9, K_A..K_D, K_STAR, K_HASH);
  - the function key_is_digit/key_digit;
  - the scan-class and command-FSM state enums.
- Sub-module teclado_scan contains row drive, synchronizer, snapshot, classifier and debounce, and outputs key_code/key_valid.
- The top level teclado_ctrl instantiates teclado_scan and contains the command FSM.

## Test plan
The bench uses CLK_HZ=32 and ROW_HZ=4, giving SCAN_DIV=8 and DEB_SCANS=2. A keypad model pulls columna low when the pressed key's row is driven.
- Press '5' with 3 bounce toggles in the first scan, then hold: exactly one key_valid, key_code=5; no further event while held.
- Sequence '1','2','#': speed=12 (≤15), is_done pulse one cycle after the '#' key_valid; FSM IDLE.
- Sequence '9','9','#': speed=15 (clamped); then '7','#' gives speed=7; then '#' alone gives an err pulse with speed held at 7.
- Hold '1' and '2' together, release to '2' only, then release all: no key_valid during the overlap or single-'2' phase.
- Sequence '4','5','6': err on '6' with acc=45. Then 'B' gives turn=1 with entry kept, and 'C' gives speed=0 with an is_done pulse.
- Assert rst_n low mid-entry after '3': all outputs return to reset values. After release, fila=4'b1110, and '#' alone pulses err.
